divisor_entero_param: RTL and testbench

- Parametrised successor to the button-driven integer divider.
- Two operand registers (dividend, divisor) are edited with up/down buttons; `selector` picks which one is being edited.
- A rising edge on `ok` launches an iterative restoring division, one quotient bit per clock, with busy/done handshake and a divide-by-zero flag.
- Sits between the board push-button/switch inputs and the result display logic.

---
 rtl/divisor_pkg.sv | 22 ++
 rtl/divisor_entero_param_if.sv | 40 ++++
 rtl/divisor_restoring_core.sv | 81 ++++++++
 rtl/divisor_entero_param.sv | 138 +++++++++++++
 tb/tb_divisor_entero_param.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/divisor_pkg.sv
// ----------------------------------------------------------------------------
// divisor_pkg
// Shared definitions for the button-driven parametrised integer divider.
//   state_t   : controller states (IDLE, CALC, DONE)
//   DEF_WIDTH : default operand/result width
//   MAX_WIDTH : widest supported operand width
//   ALL_ONES  : all-ones pattern, sliced to WIDTH for the divide-by-zero quotient
// ----------------------------------------------------------------------------
package divisor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 4;
   localparam int MAX_WIDTH = 16;

   localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

endpackage

// File: rtl/divisor_entero_param_if.sv
// ----------------------------------------------------------------------------
// divisor_entero_param_if
// Groups the button inputs and display/handshake outputs of the divider.
//   master : board side (drives up/down/selector/ok, observes results)
//   slave  : divider side
// Signals:
//   up, down, selector, ok         : operand editing and start request
//   dividendo, divisor             : current operand registers
//   cociente, resto                : results of the last completed division
//   busy, done, div_cero           : progress, completion pulse, zero-divisor flag
// ----------------------------------------------------------------------------
interface divisor_entero_param_if
   import divisor_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             up;
   logic             down;
   logic             selector;
   logic             ok;
   logic [WIDTH-1:0] dividendo;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] cociente;
   logic [WIDTH-1:0] resto;
   logic             busy;
   logic             done;
   logic             div_cero;

   modport master (
      output up, down, selector, ok,
      input  dividendo, divisor, cociente, resto, busy, done, div_cero
   );

   modport slave (
      input  up, down, selector, ok,
      output dividendo, divisor, cociente, resto, busy, done, div_cero
   );

endinterface

// File: rtl/divisor_restoring_core.sv
// ----------------------------------------------------------------------------
// divisor_restoring_core
// Iterative restoring divider, one quotient bit per clock.
// Ports:
//   clock, reset_n   : clock and asynchronous active-low reset
//   start            : load operands and begin (divisor must be nonzero)
//   dividend_in      : dividend sampled on start
//   divisor_in       : divisor sampled on start
//   busy             : high while steps remain
//   finish           : high during the cycle whose edge performs the last step
//   quot, rem        : working quotient/remainder (final once busy drops)
// ----------------------------------------------------------------------------
module divisor_restoring_core
   import divisor_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   output logic             busy,
   output logic             finish,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] quot_reg;
   logic [WIDTH-1:0] dsr_reg;
   logic [CW-1:0]    cnt_reg;
   logic             busy_reg;

   // The shifted partial remainder is WIDTH+1 bits so the compare never
   // overflows. After a successful subtract the result is below the divisor,
   // so the low WIDTH bits of a modular subtract are exact.
   logic [WIDTH:0]   rem_shift;
   logic             fits;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quot_next;

   always_comb begin
      rem_shift = {rem_reg, quot_reg[WIDTH-1]};
      fits      = (rem_shift >= {1'b0, dsr_reg});
      rem_next  = fits ? (rem_shift[WIDTH-1:0] - dsr_reg) : rem_shift[WIDTH-1:0];
      quot_next = {quot_reg[WIDTH-2:0], fits};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rem_reg  <= '0;
         quot_reg <= '0;
         dsr_reg  <= '0;
         cnt_reg  <= '0;
         busy_reg <= 1'b0;
      end else if (start) begin
         rem_reg  <= '0;
         quot_reg <= dividend_in;
         dsr_reg  <= divisor_in;
         cnt_reg  <= CW'(WIDTH - 1);
         busy_reg <= 1'b1;
      end else if (busy_reg) begin
         rem_reg  <= rem_next;
         quot_reg <= quot_next;
         if (cnt_reg == '0) begin
            busy_reg <= 1'b0;
         end else begin
            cnt_reg <= cnt_reg - 1'b1;
         end
      end
   end

   assign busy   = busy_reg;
   assign finish = busy_reg && (cnt_reg == '0);
   assign quot   = quot_reg;
   assign rem    = rem_reg;

endmodule

// File: rtl/divisor_entero_param.sv
// ----------------------------------------------------------------------------
// divisor_entero_param
// Button-driven parametrised integer divider. Two operand registers are
// edited with up/down (selector picks dividend=0 / divisor=1) while idle;
// a rising edge on ok starts a restoring division in divisor_restoring_core.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : up, down, selector, ok in; dividendo, divisor,
//                    cociente, resto, busy, done, div_cero out
// Build option:
//   DIVISOR_SAT_EN : operand editing saturates at 0 and max instead of wrapping
// ----------------------------------------------------------------------------
module divisor_entero_param
   import divisor_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset_n,
   divisor_entero_param_if.slave  bus
);

   state_t           state_reg;
   logic             ok_q_reg;
   logic             zero_reg;
   logic [WIDTH-1:0] dvd_hold_reg;
   logic             done_reg;
   logic             div_cero_reg;
   logic [WIDTH-1:0] coc_reg;
   logic [WIDTH-1:0] resto_reg;

   logic [WIDTH-1:0] opnd_val [2];
   logic             ok_rise;
   logic             core_start;
   logic             core_busy;
   logic             core_finish;
   logic [WIDTH-1:0] core_quot;
   logic [WIDTH-1:0] core_rem;

   assign ok_rise    = bus.ok & ~ok_q_reg;
   assign core_start = (state_reg == IDLE) && ok_rise && (opnd_val[1] != '0);

   // Operand registers: index 0 is the dividend, index 1 the divisor.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gen_opnd
         logic [WIDTH-1:0] opnd_reg;
         logic [WIDTH-1:0] inc_val;
         logic [WIDTH-1:0] dec_val;
         logic             edit_en;

`ifdef DIVISOR_SAT_EN
         assign inc_val = (opnd_reg == '1) ? opnd_reg : opnd_reg + 1'b1;
         assign dec_val = (opnd_reg == '0) ? opnd_reg : opnd_reg - 1'b1;
`else
         assign inc_val = opnd_reg + 1'b1;
         assign dec_val = opnd_reg - 1'b1;
`endif

         assign edit_en = (state_reg == IDLE) && (bus.selector == 1'(gi));

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               opnd_reg <= '0;
            end else if (edit_en && bus.up && !bus.down) begin
               opnd_reg <= inc_val;
            end else if (edit_en && bus.down && !bus.up) begin
               opnd_reg <= dec_val;
            end
         end

         assign opnd_val[gi] = opnd_reg;
      end
   endgenerate

   divisor_restoring_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (core_start),
      .dividend_in (opnd_val[0]),
      .divisor_in  (opnd_val[1]),
      .busy        (core_busy),
      .finish      (core_finish),
      .quot        (core_quot),
      .rem         (core_rem)
   );

   // Result registers are loaded on the edge that leaves DONE, so done and
   // the new results appear together one cycle after the state enters DONE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         ok_q_reg     <= 1'b0;
         zero_reg     <= 1'b0;
         dvd_hold_reg <= '0;
         done_reg     <= 1'b0;
         div_cero_reg <= 1'b0;
         coc_reg      <= '0;
         resto_reg    <= '0;
      end else begin
         ok_q_reg <= bus.ok;
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (ok_rise) begin
                  zero_reg     <= (opnd_val[1] == '0);
                  dvd_hold_reg <= opnd_val[0];
                  state_reg    <= (opnd_val[1] == '0) ? DONE : CALC;
               end
            end
            CALC: begin
               if (core_finish) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               state_reg    <= IDLE;
               done_reg     <= 1'b1;
               div_cero_reg <= zero_reg;
               coc_reg      <= zero_reg ? ALL_ONES[WIDTH-1:0] : core_quot;
               resto_reg    <= zero_reg ? dvd_hold_reg : core_rem;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.dividendo = opnd_val[0];
   assign bus.divisor   = opnd_val[1];
   assign bus.cociente  = coc_reg;
   assign bus.resto     = resto_reg;
   assign bus.busy      = core_busy;
   assign bus.done      = done_reg;
   assign bus.div_cero  = div_cero_reg;

endmodule

// File: tb/tb_divisor_entero_param.sv
// ----------------------------------------------------------------------------
// tb_divisor_entero_param
// Directed plus randomized bench for divisor_entero_param (WIDTH=4).
// Expected results come from plain integer / and % plus a simple operand
// model that follows the editing rules (wrap, or saturate with DIVISOR_SAT_EN).
// ----------------------------------------------------------------------------
module tb_divisor_entero_param;

   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   always #5 clock = ~clock;

   divisor_entero_param_if #(.WIDTH(W)) bus ();

   divisor_entero_param #(.WIDTH(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int mdvd        = 0;
   int mdsr        = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int edit_model(input int v, input bit inc);
`ifdef DIVISOR_SAT_EN
      if (inc) return (v == MAXV) ? v : v + 1;
      else     return (v == 0) ? 0 : v - 1;
`else
      if (inc) return (v + 1) % (MAXV + 1);
      else     return (v + MAXV) % (MAXV + 1);
`endif
   endfunction

   // Hold the given buttons for n clocks, then release.
   task automatic press(input bit sel, input bit u, input bit d, input int n);
      bus.selector = sel;
      bus.up       = u;
      bus.down     = d;
      repeat (n) begin
         tick();
         if (u ^ d) begin
            if (sel) mdsr = edit_model(mdsr, u);
            else     mdvd = edit_model(mdvd, u);
         end
      end
      bus.up   = 1'b0;
      bus.down = 1'b0;
   endtask

   task automatic set_ops(input int a, input int b);
      press(1'b0, a > mdvd, a < mdvd, (a > mdvd) ? a - mdvd : mdvd - a);
      press(1'b1, b > mdsr, b < mdsr, (b > mdsr) ? b - mdsr : mdsr - b);
      check("dividendo", bus.dividendo, mdvd);
      check("divisor", bus.divisor, mdsr);
   endtask

   task automatic run_div(input string tag, input bit hold_ok, input bit poke_up);
      int a, b, lat, busy_cnt, done_cnt, exp_lat;
      a        = mdvd;
      b        = mdsr;
      exp_lat  = (b == 0) ? 1 : W + 1;
      bus.ok   = 1'b1;
      tick();
      if (!hold_ok) bus.ok = 1'b0;
      busy_cnt = bus.busy ? 1 : 0;
      lat      = 0;
      if (poke_up) begin
         bus.selector = 1'b0;
         bus.up       = 1'b1;
      end
      while (lat < 20 && bus.done !== 1'b1) begin
         tick();
         lat++;
         if (bus.busy === 1'b1 && bus.done !== 1'b1) busy_cnt++;
      end
      bus.up = 1'b0;
      check($sformatf("%s latency", tag), lat, exp_lat);
      check($sformatf("%s busy_cycles", tag), busy_cnt, (b == 0) ? 0 : W);
      check($sformatf("%s cociente", tag), bus.cociente, (b == 0) ? MAXV : a / b);
      check($sformatf("%s resto", tag), bus.resto, (b == 0) ? a : a % b);
      check($sformatf("%s div_cero", tag), bus.div_cero, (b == 0) ? 1 : 0);
      done_cnt = 0;
      repeat (4) begin
         tick();
         if (bus.done === 1'b1) done_cnt++;
      end
      check($sformatf("%s extra_done", tag), done_cnt, 0);
      check($sformatf("%s hold_cociente", tag), bus.cociente, (b == 0) ? MAXV : a / b);
      bus.ok = 1'b0;
      check($sformatf("%s dividendo_kept", tag), bus.dividendo, mdvd);
      check($sformatf("%s divisor_kept", tag), bus.divisor, mdsr);
      $display("div %s: %0d / %0d -> q=%0d r=%0d z=%0d lat=%0d", tag, a, b,
               bus.cociente, bus.resto, bus.div_cero, lat);
   endtask

   task automatic check_all_zero(input string tag);
      check($sformatf("%s dividendo", tag), bus.dividendo, 0);
      check($sformatf("%s divisor", tag), bus.divisor, 0);
      check($sformatf("%s cociente", tag), bus.cociente, 0);
      check($sformatf("%s resto", tag), bus.resto, 0);
      check($sformatf("%s busy", tag), bus.busy, 0);
      check($sformatf("%s done", tag), bus.done, 0);
      check($sformatf("%s div_cero", tag), bus.div_cero, 0);
   endtask

   initial begin
      int a, b, done_cnt;
      bus.up       = 1'b0;
      bus.down     = 1'b0;
      bus.selector = 1'b0;
      bus.ok       = 1'b0;

      // Reset state
      repeat (2) tick();
      check_all_zero("reset");
      reset_n = 1'b1;
      tick();

      // 7 ups, 2 downs on dividend; 2 ups on divisor; 5/2
      press(1'b0, 1'b1, 1'b0, 7);
      press(1'b0, 1'b0, 1'b1, 2);
      check("edit_dividendo", bus.dividendo, 5);
      press(1'b1, 1'b1, 1'b0, 2);
      check("edit_divisor", bus.divisor, 2);
      run_div("5/2", 1'b0, 1'b0);

      set_ops(15, 4);
      run_div("15/4", 1'b0, 1'b0);
      set_ops(3, 7);
      run_div("3/7", 1'b0, 1'b0);

      // Divide by zero
      set_ops(9, 0);
      run_div("9/0", 1'b0, 1'b0);

      // Reset mid-CALC, results above are nonzero
      set_ops(13, 3);
      bus.ok = 1'b1;
      tick();
      bus.ok = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      check_all_zero("midcalc_reset");
      tick();
      reset_n = 1'b1;
      mdvd = 0;
      mdsr = 0;
      done_cnt = 0;
      repeat (8) begin
         tick();
         if (bus.done === 1'b1) done_cnt++;
      end
      check("midcalc_no_done", done_cnt, 0);
      set_ops(11, 3);
      run_div("11/3", 1'b0, 1'b0);

      // Edit boundaries
      set_ops(15, 3);
      press(1'b0, 1'b1, 1'b0, 1);
      check("dividendo_max_up", bus.dividendo, mdvd);
      set_ops(mdvd, 0);
      press(1'b1, 1'b0, 1'b1, 1);
      check("divisor_zero_down", bus.divisor, mdsr);

      // ok held through completion, up pressed during CALC
      set_ops(14, 5);
      run_div("14/5_hold", 1'b1, 1'b1);

      // Both buttons: no change
      press(1'b0, 1'b1, 1'b1, 3);
      check("updown_dividendo", bus.dividendo, 14);
      press(1'b1, 1'b1, 1'b1, 3);
      check("updown_divisor", bus.divisor, 5);

      // Randomized operands
      for (int i = 0; i < 12; i++) begin
         a = int'($urandom_range(0, MAXV));
         b = (i % 5 == 4) ? 0 : int'($urandom_range(0, MAXV));
         set_ops(a, b);
         run_div($sformatf("rnd%0d", i), 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
